instr_fetch_unit: RTL and testbench

Upstream stage of exec_unit. Autonomously fetches 16-bit big-endian instructions from byte-wide RAM: MSB at fetch_pc, LSB at fetch_pc+1. Fetched instructions go into a small circular instruction queue. exec_unit drains the queue through a valid/ready handshake and redirects the fetch stream on taken jumps. The block owns the RAM read port during fetch; all addresses are 8-bit and wrap modulo 256.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch bus bundling the RAM read port, the redirect request and the instruction-queue handshake.
`timescale 1ns/1ps
interface instr_fetch_unit_if #(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 8,
  parameter int QUEUE_DEPTH = 4
) ();
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  logic                   fetch_enable;
  logic                   rd_ram_en;
  logic [ADDR_BITS-1:0]   rd_ram_addr;
  logic [DATA_BITS-1:0]   rd_ram_data;
  logic                   redirect_valid;
  logic [ADDR_BITS-1:0]   redirect_pc;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [2*DATA_BITS-1:0] inst_data;
  logic [ADDR_BITS-1:0]   inst_pc;
  logic [CW-1:0]          queue_count;
  modport slave (
    input  fetch_enable, rd_ram_data, redirect_valid, redirect_pc, inst_ready,
    output rd_ram_en, rd_ram_addr, inst_valid, inst_data, inst_pc, queue_count
  );
  modport master (
    output fetch_enable, rd_ram_data, redirect_valid, redirect_pc, inst_ready,
    input  rd_ram_en, rd_ram_addr, inst_valid, inst_data, inst_pc, queue_count
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 16-bit big-endian instructions into a circular queue; FETCH_PERF_EN adds push/flush counters.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 8,
  parameter int QUEUE_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input logic clk,
  input logic reset,
  instr_fetch_unit_if.slave bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_flushes
`endif
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE_MSB, ISSUE_LSB, COMPLETE} state_e;
  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   fetch_pc_q, fetch_pc_d, addr_q;
  logic [DATA_BITS-1:0]   msb_q;
  logic [2*DATA_BITS-1:0] data_q [QUEUE_DEPTH];
  logic [ADDR_BITS-1:0]   pc_q [QUEUE_DEPTH];
  logic [PW-1:0]          head_q, tail_q;
  logic [CW-1:0]          count_q;
  logic                   push, pop;

  assign bus.inst_valid  = (count_q != '0) && !bus.redirect_valid;
  assign bus.inst_data   = data_q[head_q];
  assign bus.inst_pc     = pc_q[head_q];
  assign bus.queue_count = count_q;
  assign pop             = bus.inst_valid && bus.inst_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Full check uses the registered count, so a same-cycle pop cannot unblock an issue.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    bus.rd_ram_en   = 1'b0;
    bus.rd_ram_addr = addr_q;
    push            = 1'b0;
    case (state_q)
      IDLE: state_d = ISSUE_MSB;
      ISSUE_MSB: begin
        if (bus.fetch_enable && count_q < CW'(QUEUE_DEPTH)) begin
          bus.rd_ram_en   = 1'b1;
          bus.rd_ram_addr = fetch_pc_q;
          state_d         = ISSUE_LSB;
        end
      end
      ISSUE_LSB: begin
        bus.rd_ram_en   = 1'b1;
        bus.rd_ram_addr = fetch_pc_q + ADDR_BITS'(1);
        state_d         = COMPLETE;
      end
      COMPLETE: begin
        push       = 1'b1;
        fetch_pc_d = fetch_pc_q + ADDR_BITS'(2);
        state_d    = ISSUE_MSB;
      end
    endcase
    if (bus.redirect_valid) begin
      push       = 1'b0;
      fetch_pc_d = bus.redirect_pc;
      state_d    = ISSUE_MSB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= ADDR_BITS'(RESET_PC);
      addr_q     <= '0;
      msb_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (bus.rd_ram_en) addr_q <= bus.rd_ram_addr;
      if (state_q == ISSUE_LSB) msb_q <= bus.rd_ram_data;
      if (bus.redirect_valid) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          data_q[tail_q] <= {msb_q, bus.rd_ram_data};
          pc_q[tail_q]   <= fetch_pc_q;
          tail_q         <= tail_q + PW'(1);
        end
        if (pop) head_q <= head_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (push && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
      if (bus.redirect_valid && (count_q != '0 || state_q != ISSUE_MSB) && perf_flushes != 16'hFFFF)
        perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: transaction-level model of fetch/queue compared every cycle, plus hand-computed directed checks.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  typedef struct packed {logic [15:0] d; logic [7:0] pc;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_unit_if #(.ADDR_BITS(8), .DATA_BITS(8), .QUEUE_DEPTH(4)) bus ();
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_flushes;
`endif
  instr_fetch_unit #(.ADDR_BITS(8), .DATA_BITS(8), .QUEUE_DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushes(perf_flushes)
`endif
  );

  logic [7:0] mem [256];
  logic [7:0] rdata = 8'h00;
  always @(posedge clk) if (bus.rd_ram_en) rdata <= mem[bus.rd_ram_addr];
  assign bus.rd_ram_data = rdata;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of whole instructions; a fetch spans three cycles and reads both bytes from mem when it lands.
  ent_t       mq[$];
  int         stage = -1;
  logic [7:0] mpc = 8'h00;
  logic [7:0] mlast = 8'h00;
  int         m_fetched = 0;
  int         m_flushes = 0;
  logic [7:0] alog[$];

  function automatic logic exp_en();
    return (stage == 0 && bus.fetch_enable && mq.size() < 4) || stage == 1;
  endfunction
  function automatic logic [7:0] exp_addr();
    return stage == 1 ? mpc + 8'd1 : exp_en() ? mpc : mlast;
  endfunction
  function automatic logic exp_valid();
    return mq.size() != 0 && !bus.redirect_valid;
  endfunction

  always @(posedge clk or posedge reset) begin
    int n;
    ent_t e;
    logic [7:0] a1;
    if (reset) begin
      mq.delete();
      stage = -1;
      mpc = 8'h00;
      mlast = 8'h00;
      m_fetched = 0;
      m_flushes = 0;
    end else begin
      if (exp_en()) mlast = exp_addr();
      if (bus.redirect_valid) begin
        if (mq.size() != 0 || stage != 0) m_flushes = m_flushes < 65535 ? m_flushes + 1 : m_flushes;
        mq.delete();
        mpc = bus.redirect_pc;
        stage = 0;
      end else begin
        n = mq.size();
        if (exp_valid() && bus.inst_ready) void'(mq.pop_front());
        if (stage == -1) stage = 0;
        else if (stage == 0) stage = (bus.fetch_enable && n < 4) ? 1 : 0;
        else if (stage == 1) stage = 2;
        else begin
          a1 = mpc + 8'd1;
          e.d = {mem[mpc], mem[a1]};
          e.pc = mpc;
          mq.push_back(e);
          mpc = mpc + 8'd2;
          m_fetched = m_fetched < 65535 ? m_fetched + 1 : m_fetched;
          stage = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (bus.rd_ram_en) alog.push_back(bus.rd_ram_addr);
      chk("inst_valid", 32'(bus.inst_valid), 32'(exp_valid()));
      chk("queue_count", 32'(bus.queue_count), 32'(mq.size()));
      chk("rd_ram_en", 32'(bus.rd_ram_en), 32'(exp_en()));
      chk("rd_ram_addr", 32'(bus.rd_ram_addr), 32'(exp_addr()));
      if (mq.size() != 0) begin
        chk("inst_data", 32'(bus.inst_data), 32'(mq[0].d));
        chk("inst_pc", 32'(bus.inst_pc), 32'(mq[0].pc));
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetched", 32'(perf_fetched), 32'(m_fetched));
      chk("perf_flushes", 32'(perf_flushes), 32'(m_flushes));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.fetch_enable = 1'b1;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 29 + 7);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    mem[3] = 8'h78; mem[4] = 8'h9A; mem[5] = 8'hBC;
    mem[8'h40] = 8'hDE; mem[8'h41] = 8'hAD; mem[8'hFF] = 8'hA1;
    tick(2);
    reset = 1'b0;
    #3;
    chk("rst_count", 32'(bus.queue_count), 0);
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_en", 32'(bus.rd_ram_en), 0);
    chk("rst_addr", 32'(bus.rd_ram_addr), 0);
    chk("rst_data", 32'(bus.inst_data), 0);
    chk("rst_pc", 32'(bus.inst_pc), 0);
    tick(3); #3;
    chk("first_valid_early", 32'(bus.inst_valid), 0);
    tick(1); #3;
    chk("first_valid", 32'(bus.inst_valid), 1);
    chk("first_data", 32'(bus.inst_data), 32'h1234);
    tick(6); #3;
    chk("three_count", 32'(bus.queue_count), 3);
    chk("three_head", 32'(bus.inst_data), 32'h1234);
    for (int i = 0; i < 6; i++) chk("addr_seq", 32'(i < alog.size() ? alog[i] : 8'hEE), i);
    tick(5);
    bus.inst_ready = 1'b1;
    #3;
    chk("full_count", 32'(bus.queue_count), 4);
    chk("full_en", 32'(bus.rd_ram_en), 0);
    chk("full_valid", 32'(bus.inst_valid), 1);
    tick(1);
    bus.inst_ready = 1'b0;
    #3;
    chk("refill_en", 32'(bus.rd_ram_en), 1);
    chk("refill_addr", 32'(bus.rd_ram_addr), 32'h08);
    tick(5);
    #3;
    chk("refull_count", 32'(bus.queue_count), 4);
    chk("refull_pc", 32'(bus.inst_pc), 32'h02);
    chk("refull_data", 32'(bus.inst_data), 32'h5678);
    bus.fetch_enable = 1'b0;
    bus.inst_ready = 1'b1;
    tick(2);
    bus.inst_ready = 1'b0;
    bus.fetch_enable = 1'b1;
    #3;
    chk("drain_count", 32'(bus.queue_count), 2);
    chk("drain_pc", 32'(bus.inst_pc), 32'h06);
    tick(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h40;
    bus.inst_ready = 1'b1;
    #3;
    chk("redir_valid_mask", 32'(bus.inst_valid), 0);
    chk("redir_lsb_addr", 32'(bus.rd_ram_addr), 32'h0B);
    tick(1);
    bus.redirect_valid = 1'b0;
    bus.inst_ready = 1'b0;
    #3;
    chk("redir_count", 32'(bus.queue_count), 0);
    chk("redir_addr", 32'(bus.rd_ram_addr), 32'h40);
    tick(3); #3;
    chk("redir_entry_valid", 32'(bus.inst_valid), 1);
    chk("redir_entry_pc", 32'(bus.inst_pc), 32'h40);
    chk("redir_entry_data", 32'(bus.inst_data), 32'hDEAD);
    tick(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'hFF;
    mem[0] = 8'hB2;
    tick(1);
    bus.redirect_valid = 1'b0;
    #3;
    chk("wrap_msb_addr", 32'(bus.rd_ram_addr), 32'hFF);
    tick(1); #3;
    chk("wrap_lsb_addr", 32'(bus.rd_ram_addr), 32'h00);
    tick(2); #3;
    chk("wrap_data", 32'(bus.inst_data), 32'hA1B2);
    chk("wrap_pc", 32'(bus.inst_pc), 32'hFF);
    chk("wrap_next_addr", 32'(bus.rd_ram_addr), 32'h01);
    tick(5);
    bus.inst_ready = 1'b1;
    #3;
    chk("pushpop_before", 32'(bus.queue_count), 2);
    chk("pushpop_complete_en", 32'(bus.rd_ram_en), 0);
    tick(1);
    bus.inst_ready = 1'b0;
    #3;
    chk("pushpop_after", 32'(bus.queue_count), 2);
    tick(1);
    reset = 1'b1;
    #3;
    chk("midrst_count", 32'(bus.queue_count), 0);
    chk("midrst_valid", 32'(bus.inst_valid), 0);
    chk("midrst_en", 32'(bus.rd_ram_en), 0);
    tick(1);
    reset = 1'b0;
    tick(4); #3;
    chk("midrst_first_data", 32'(bus.inst_data), 32'hB234);
    chk("midrst_first_pc", 32'(bus.inst_pc), 0);
    tick(11);
    bus.inst_ready = 1'b1;
    #3;
    chk("perf_full_count", 32'(bus.queue_count), 4);
    tick(1);
    bus.inst_ready = 1'b0;
    #3;
    chk("perf_fifth_addr", 32'(bus.rd_ram_addr), 32'h08);
    tick(3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h20;
    tick(1);
    bus.redirect_valid = 1'b0;
    tick(1);
    bus.redirect_valid = 1'b1;
    #3;
    chk("perf_lsb_en", 32'(bus.rd_ram_en), 1);
    tick(1);
    bus.redirect_valid = 1'b0;
    bus.fetch_enable = 1'b0;
    #3;
    chk("perf_final_count", 32'(bus.queue_count), 0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_lit", 32'(perf_fetched), 5);
    chk("perf_flushes_lit", 32'(perf_flushes), 2);
`endif
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
